// File: rtl/hall_call_dispatcher.sv
// hall_call_dispatcher: latches hall calls, scans them round-robin and hands each to the cheaper of two cars.
// Optional DISPATCH_REASSIGN_EN: assignments that age out are re-offered to the other car.
module hall_call_dispatcher #(
  parameter int FLOOR_MIN = 1,
  parameter int FLOOR_MAX = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [FLOOR_MAX-1:0] hall_up_req,
  input  logic [FLOOR_MAX-1:0] hall_down_req,
  input  logic [3:0]           car0_floor,
  input  logic [1:0]           car0_state,
  input  logic                 car0_door,
  input  logic [3:0]           car1_floor,
  input  logic [1:0]           car1_state,
  input  logic                 car1_door,
  output logic [FLOOR_MAX-1:0] car0_up_req,
  output logic [FLOOR_MAX-1:0] car0_down_req,
  output logic [FLOOR_MAX-1:0] car1_up_req,
  output logic [FLOOR_MAX-1:0] car1_down_req,
  output logic [FLOOR_MAX-1:0] up_lamp,
  output logic [FLOOR_MAX-1:0] down_lamp,
  output logic                 busy
);
  localparam int NS = 2 * FLOOR_MAX;
  localparam int PW = $clog2(NS);
  localparam logic [3:0] FMIN = 4'(FLOOR_MIN);
  localparam logic [3:0] FMAX = 4'(FLOOR_MAX);
  localparam logic [5:0] PENALTY = 6'(NS);
  localparam logic [5:0] NO_CAR = 6'd63;
  localparam logic [PW-1:0] LAST = PW'(NS - 1);
  localparam logic [FLOOR_MAX-1:0] BOTTOM = {{(FLOOR_MAX-1){1'b0}}, 1'b1};
  localparam logic [FLOOR_MAX-1:0] TOP = {1'b1, {(FLOOR_MAX-1){1'b0}}};
  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_COST, S_ASSIGN} state_t;
  state_t state_q, state_d;
  logic [FLOOR_MAX-1:0] up_btn_q, dn_btn_q;
  logic [NS-1:0] pend_q, pend_d, asg_q, asg_d, own_q, own_d;
  logic [NS-1:0] serve, press, unasg, live, expire, excl_q, exown_q;
  logic [PW-1:0] ptr_q, ptr_d, slot_q, slot_d, ptr_nx;
  logic [5:0] cost0_q, cost0_d, cost1_q, cost1_d;
  logic [3:0] call_floor;
  logic call_up;

  function automatic logic [5:0] car_cost(input logic [3:0] cf, input logic [1:0] st,
                                          input logic [3:0] f, input logic up);
    logic [5:0] d;
    d = {2'b00, (cf > f) ? cf - f : f - cf};
    if (st == 2'b11 || cf < FMIN || cf > FMAX) return NO_CAR;
    if (st == 2'b01) return (up && f >= cf) ? d : d + PENALTY;
    if (st == 2'b10) return (!up && f <= cf) ? d : d + PENALTY;
    return d;
  endfunction

  // Floor 1 has no down button and the top floor no up button.
  assign press = {hall_down_req & ~dn_btn_q & ~BOTTOM, hall_up_req & ~up_btn_q & ~TOP};
  assign unasg = pend_q & ~asg_q;
  assign ptr_nx = (ptr_q == LAST) ? '0 : ptr_q + 1'b1;
  assign call_up = slot_q < PW'(FLOOR_MAX);
  assign call_floor = 4'(call_up ? slot_q : slot_q - PW'(FLOOR_MAX)) + 4'd1;

  always_comb begin
    serve = '0;
    for (int i = 0; i < FLOOR_MAX; i++) begin
      serve[i] = (car0_door && car0_floor == 4'(i + 1) && !car0_state[1]) ||
                 (car1_door && car1_floor == 4'(i + 1) && !car1_state[1]);
      serve[FLOOR_MAX + i] = (car0_door && car0_floor == 4'(i + 1) && !car0_state[0]) ||
                             (car1_door && car1_floor == 4'(i + 1) && !car1_state[0]);
    end
  end

`ifdef DISPATCH_REASSIGN_EN
  logic [7:0] age_q [NS];
  logic [7:0] age_d [NS];
  logic [NS-1:0] excl_d, exown_d;
  // An expired slot remembers its previous owner so that car is priced out on the rescan.
  always_comb begin
    for (int s = 0; s < NS; s++) begin
      expire[s] = asg_q[s] && age_q[s] == 8'hff;
      age_d[s] = (asg_q[s] && !expire[s]) ? age_q[s] + 8'd1 : 8'd0;
    end
    excl_d = (excl_q | expire) & ~serve;
    exown_d = ((exown_q & ~expire) | (own_q & expire)) & ~serve;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NS; s++) age_q[s] <= '0;
      excl_q <= '0;
      exown_q <= '0;
    end else begin
      for (int s = 0; s < NS; s++) age_q[s] <= age_d[s];
      excl_q <= excl_d;
      exown_q <= exown_d;
    end
  end
`else
  assign expire = '0;
  assign excl_q = '0;
  assign exown_q = '0;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    slot_d = slot_q;
    cost0_d = cost0_q;
    cost1_d = cost1_q;
    asg_d = asg_q & ~expire;
    own_d = own_q;
    case (state_q)
      S_IDLE: state_d = |unasg ? S_SCAN : S_IDLE;
      S_SCAN: begin
        state_d = !(|unasg) ? S_IDLE : unasg[ptr_q] ? S_COST : S_SCAN;
        slot_d = ptr_q;
        ptr_d = (|unasg && !unasg[ptr_q]) ? ptr_nx : ptr_q;
      end
      S_COST: begin
        cost0_d = (excl_q[slot_q] && !exown_q[slot_q]) ? NO_CAR :
                  car_cost(car0_floor, car0_state, call_floor, call_up);
        cost1_d = (excl_q[slot_q] && exown_q[slot_q]) ? NO_CAR :
                  car_cost(car1_floor, car1_state, call_floor, call_up);
        state_d = S_ASSIGN;
      end
      S_ASSIGN: begin
        if (unasg[slot_q] && (cost0_q < NO_CAR || cost1_q < NO_CAR)) begin
          asg_d[slot_q] = 1'b1;
          own_d[slot_q] = cost1_q < cost0_q;
        end
        ptr_d = ptr_nx;
        state_d = S_SCAN;
      end
      default: state_d = S_IDLE;
    endcase
    pend_d = (pend_q | press) & ~serve;
    asg_d = asg_d & ~serve;
    own_d = own_d & ~serve;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      up_btn_q <= '0;
      dn_btn_q <= '0;
      pend_q <= '0;
      asg_q <= '0;
      own_q <= '0;
      ptr_q <= '0;
      slot_q <= '0;
      cost0_q <= '0;
      cost1_q <= '0;
    end else begin
      state_q <= state_d;
      up_btn_q <= hall_up_req;
      dn_btn_q <= hall_down_req;
      pend_q <= pend_d;
      asg_q <= asg_d;
      own_q <= own_d;
      ptr_q <= ptr_d;
      slot_q <= slot_d;
      cost0_q <= cost0_d;
      cost1_q <= cost1_d;
    end
  end

  assign live = pend_q & asg_q;
  assign car0_up_req = live[FLOOR_MAX-1:0] & ~own_q[FLOOR_MAX-1:0];
  assign car0_down_req = live[NS-1:FLOOR_MAX] & ~own_q[NS-1:FLOOR_MAX];
  assign car1_up_req = live[FLOOR_MAX-1:0] & own_q[FLOOR_MAX-1:0];
  assign car1_down_req = live[NS-1:FLOOR_MAX] & own_q[NS-1:FLOOR_MAX];
  assign up_lamp = pend_q[FLOOR_MAX-1:0];
  assign down_lamp = pend_q[NS-1:FLOOR_MAX];
  assign busy = state_q != S_IDLE;
endmodule

// File: tb/tb_hall_call_dispatcher.sv
// tb_hall_call_dispatcher: directed and randomized calls checked against a spec-level cost/lamp model.
module tb_hall_call_dispatcher;
  localparam int FM = 8;
  localparam int BUDGET = 2 * FM + 4;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [FM-1:0] hall_up_req = '0, hall_down_req = '0;
  logic [3:0] car0_floor = 4'd1, car1_floor = 4'd8;
  logic [1:0] car0_state = 2'd0, car1_state = 2'd0;
  logic car0_door = 1'b0, car1_door = 1'b0;
  logic [FM-1:0] car0_up_req, car0_down_req, car1_up_req, car1_down_req, up_lamp, down_lamp;
  logic busy;
  logic [FM-1:0] exp_up = '0, exp_dn = '0;
  int checks = 0, passes = 0;

  hall_call_dispatcher #(.FLOOR_MIN(1), .FLOOR_MAX(FM)) dut (
    .clk(clk), .rst_n(rst_n),
    .hall_up_req(hall_up_req), .hall_down_req(hall_down_req),
    .car0_floor(car0_floor), .car0_state(car0_state), .car0_door(car0_door),
    .car1_floor(car1_floor), .car1_state(car1_state), .car1_door(car1_door),
    .car0_up_req(car0_up_req), .car0_down_req(car0_down_req),
    .car1_up_req(car1_up_req), .car1_down_req(car1_down_req),
    .up_lamp(up_lamp), .down_lamp(down_lamp), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic int mcost(input int cf, input int st, input int f, input bit up);
    int d = cf > f ? cf - f : f - cf;
    if (st == 3 || cf < 1 || cf > FM) return 63;
    if (st == 0) return d;
    if (st == 1) return (up && f >= cf) ? d : d + 2 * FM;
    return (!up && f <= cf) ? d : d + 2 * FM;
  endfunction

  function automatic logic req(input int car, input bit up, input int i);
    return car == 0 ? (up ? car0_up_req[i] : car0_down_req[i]) : (up ? car1_up_req[i] : car1_down_req[i]);
  endfunction

  task automatic press(input bit up, input int i);
    if (up) hall_up_req[i] = 1'b1;
    else hall_down_req[i] = 1'b1;
    tick();
    hall_up_req = '0;
    hall_down_req = '0;
    if (up && i != FM - 1) exp_up[i] = 1'b1;
    if (!up && i != 0) exp_dn[i] = 1'b1;
  endtask

  task automatic wait_req(input int car, input bit up, input int i, output bit got);
    got = 1'b0;
    for (int k = 0; k < BUDGET && !got; k++) begin
      tick();
      got = req(car, up, i);
    end
  endtask

  task automatic serve(input int car, input int fl, input bit up);
    logic [1:0] st;
    st = $urandom_range(0, 1) ? 2'd0 : (up ? 2'd1 : 2'd2);
    if (car == 0) begin
      car0_floor = 4'(fl); car0_state = st; car0_door = 1'b1;
    end else begin
      car1_floor = 4'(fl); car1_state = st; car1_door = 1'b1;
    end
    tick();
    if (st != 2'd2) exp_up[fl-1] = 1'b0;
    if (st != 2'd1) exp_dn[fl-1] = 1'b0;
    check("serve_up_lamp", 64'(up_lamp), 64'(exp_up));
    check("serve_dn_lamp", 64'(down_lamp), 64'(exp_dn));
    check("serve_reqs", {62'd0, req(0, up, fl - 1), req(1, up, fl - 1)}, 64'd0);
    car0_door = 1'b0;
    car1_door = 1'b0;
  endtask

  initial begin
    bit got;
    logic seen;
    #12;
    check("reset_outputs", {car0_up_req, car0_down_req, car1_up_req, car1_down_req, up_lamp, down_lamp}, 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    // Async reset while the scanner is pricing slot 0.
    car0_floor = 4'd4; car1_floor = 4'd8;
    press(1'b1, 0);
    check("pre_reset_lamp", 64'(up_lamp), 64'(exp_up));
    tick();
    tick();
    check("cost_busy", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_outputs", {busy, car0_up_req, car0_down_req, car1_up_req, car1_down_req, up_lamp, down_lamp}, 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    exp_up = '0;
    tick();
    check("post_rst_busy", 64'(busy), 64'd0);
    check("post_rst_lamp", 64'(up_lamp), 64'd0);
    // Basic assignment to the nearer car, then service.
    car0_floor = 4'd1; car1_floor = 4'd8;
    press(1'b1, 5);
    check("basic_lamp", 64'(up_lamp), 64'(exp_up));
    wait_req(1, 1'b1, 5, got);
    check("basic_car1", 64'(got), 64'd1);
    check("basic_car0", 64'(car0_up_req), 64'd0);
    car1_floor = 4'd6; car1_door = 1'b1; car1_state = 2'd0;
    tick();
    exp_up[5] = 1'b0;
    check("basic_clr_req", 64'(car1_up_req[5]), 64'd0);
    check("basic_clr_lamp", 64'(up_lamp), 64'(exp_up));
    car1_door = 1'b0;
    // Equal cost goes to car 0.
    car0_floor = 4'd3; car1_floor = 4'd5;
    press(1'b0, 3);
    wait_req(0, 1'b0, 3, got);
    check("tie_car0", 64'(got), 64'd1);
    check("tie_car1", {car1_up_req, car1_down_req}, 64'd0);
    serve(0, 4, 1'b0);
    // A car moving up away from the call pays the direction penalty.
    car0_floor = 4'd2; car0_state = 2'd1; car1_floor = 4'd7; car1_state = 2'd0;
    press(1'b1, 0);
    wait_req(1, 1'b1, 0, got);
    check("penalty_car1", 64'(got), 64'd1);
    check("penalty_car0", 64'(car0_up_req), 64'd0);
    serve(1, 1, 1'b1);
    // Floor 1 down and top-floor up do not exist.
    car0_state = 2'd0;
    press(1'b0, 0);
    press(1'b1, FM - 1);
    seen = 1'b0;
    repeat (50) begin
      tick();
      seen |= |{car0_up_req, car0_down_req, car1_up_req, car1_down_req, up_lamp, down_lamp};
    end
    check("masked_quiet", 64'(seen), 64'd0);
    check("masked_busy", 64'(busy), 64'd0);
    // No car available: call waits, then goes to the first car to return.
    car0_state = 2'd3; car1_state = 2'd3;
    press(1'b1, 2);
    check("unavail_lamp", 64'(up_lamp), 64'(exp_up));
    seen = 1'b0;
    repeat (30) begin
      tick();
      seen |= |{car0_up_req, car1_up_req};
    end
    check("unavail_noreq", 64'(seen), 64'd0);
    car0_state = 2'd0; car0_floor = 4'd1;
    wait_req(0, 1'b1, 2, got);
    check("unavail_recover", 64'(got), 64'd1);
    serve(0, 3, 1'b1);
    car1_state = 2'd0;
    // A held button is not re-latched once served.
    car0_floor = 4'd1; car1_floor = 4'd8;
    hall_up_req[1] = 1'b1;
    tick();
    exp_up[1] = 1'b1;
    check("hold_lamp", 64'(up_lamp), 64'(exp_up));
    wait_req(0, 1'b1, 1, got);
    check("hold_assign", 64'(got), 64'd1);
    serve(0, 2, 1'b1);
    repeat (3) tick();
    check("hold_no_relatch", 64'(up_lamp), 64'(exp_up));
    hall_up_req = '0;
    // A press at a floor where a car already stands open does not latch.
    car0_floor = 4'd5; car0_state = 2'd0; car0_door = 1'b1;
    hall_down_req[4] = 1'b1;
    tick();
    hall_down_req = '0;
    check("clear_beats_press", 64'(down_lamp), 64'(exp_dn));
    car0_door = 1'b0;
    tick();
    check("clear_beats_after", 64'(down_lamp), 64'(exp_dn));
    // Randomized single calls against the cost model.
    for (int n = 0; n < 24; n++) begin
      int f, c0, c1, own;
      bit up;
      car0_floor = 4'($urandom_range(0, 9));
      car1_floor = 4'($urandom_range(0, 9));
      car0_state = 2'($urandom_range(0, 3));
      car1_state = 2'($urandom_range(0, 3));
      up = 1'($urandom_range(0, 1));
      f = up ? int'($urandom_range(1, FM - 1)) : int'($urandom_range(2, FM));
      c0 = mcost(int'(car0_floor), int'(car0_state), f, up);
      c1 = mcost(int'(car1_floor), int'(car1_state), f, up);
      own = (c0 == 63 && c1 == 63) ? -1 : (c1 < c0 ? 1 : 0);
      press(up, f - 1);
      check("rand_lamps", {up_lamp, down_lamp}, {exp_up, exp_dn});
      if (own >= 0) begin
        wait_req(own, up, f - 1, got);
        check("rand_owner", 64'(got), 64'd1);
        check("rand_other", 64'(req(1 - own, up, f - 1)), 64'd0);
      end else begin
        seen = 1'b0;
        repeat (BUDGET) begin
          tick();
          seen |= req(0, up, f - 1) | req(1, up, f - 1);
        end
        check("rand_unassigned", 64'(seen), 64'd0);
      end
      serve(int'($urandom_range(0, 1)), f, up);
      tick();
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/hall_call_dispatcher.md
Name: hall_call_dispatcher

Overview:
- Group controller for two elevator cars.
- Latches hall up/down calls, scans them round-robin and assigns each unassigned call to the cheaper car.
- Drives each assigned call onto that car's external_up_req/external_down_req inputs until the call is served, then clears the call and its lamp.
- Sits between the hall button panel and two elevator instances.

Parameters:
- FLOOR_MIN, 1, lowest floor number.
- FLOOR_MAX, 8, highest floor; also the width of every call vector.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- hall_up_req  input  FLOOR_MAX  hall up buttons, bit i = floor i+1.
- hall_down_req  input  FLOOR_MAX  hall down buttons, bit i = floor i+1.
- car0_floor  input  4  car 0 current floor.
- car0_state  input  2  car 0 state: 00 idle, 01 up, 10 down.
- car0_door  input  1  car 0 door, 1 = open.
- car1_floor  input  4  car 1 current floor.
- car1_state  input  2  car 1 state, same encoding as car0_state.
- car1_door  input  1  car 1 door, 1 = open.
- car0_up_req  output  FLOOR_MAX  assigned up calls for car 0.
- car0_down_req  output  FLOOR_MAX  assigned down calls for car 0.
- car1_up_req  output  FLOOR_MAX  assigned up calls for car 1.
- car1_down_req  output  FLOOR_MAX  assigned down calls for car 1.
- up_lamp  output  FLOOR_MAX  pending up calls.
- down_lamp  output  FLOOR_MAX  pending down calls.
- busy  output  1  FSM not in S_IDLE.

Behaviour:
- Reset (async, rst_n=0): all outputs 0; pending, assign-valid and owner registers cleared; edge-detect registers cleared; FSM in S_IDLE; scan pointer 0.
- Call capture:
  - Button inputs are registered.
  - A rising edge sets the slot's pending bit on the following clock.
  - Holding a button does not re-latch a served call.
- Masked buttons: hall_down_req[0] (floor 1 down) and hall_up_req[FLOOR_MAX-1] (top-floor up) are ignored.
- Slot map, 2*FLOOR_MAX slots:
  - Slot i = up call at floor i+1.
  - Slot FLOOR_MAX+i = down call at floor i+1.
- Lamps: up_lamp/down_lamp equal the pending bits directly.
- Car outputs: carN_*_req[i] = pending & assigned & owner==N.
- Service/clear, evaluated every cycle for all slots:
  - A slot clears (pending, assigned, owner) when any car has floor == slot floor and door=1.
  - Up slot: that car's state must be 00 or 01.
  - Down slot: that car's state must be 00 or 10.
  - The serving car need not be the owner.
  - Clear beats a simultaneous new press on the same slot.
- FSM states:
  - S_IDLE: go to S_SCAN when any slot is pending and unassigned.
  - S_SCAN: examine the slot at the pointer. If pending and unassigned, latch slot → S_COST. Otherwise pointer+1 (wraps 2*FLOOR_MAX-1 → 0). Return to S_IDLE when no pending-unassigned slot remains.
  - S_COST: compute and register cost0/cost1 (1 cycle).
  - S_ASSIGN: if min cost < 63, set assigned and owner (ties go to car 0), else leave unassigned. Pointer+1 → S_SCAN. If the slot was cleared meanwhile, no write.
- Cost, 6-bit unsigned, per car:
  - d = |car_floor − call_floor|.
  - State 00: cost = d.
  - State 01: cost = d if call_floor ≥ car_floor and the call is up, else d + 2*FLOOR_MAX.
  - State 10: cost = d if call_floor ≤ car_floor and the call is down, else d + 2*FLOOR_MAX.
  - State 11, or car_floor outside FLOOR_MIN..FLOOR_MAX: cost = 63 (car unavailable).
- Latency: press to carN_*_req asserted ≤ 2*FLOOR_MAX+4 cycles when a car is available.
- Assignments are final; reassignment exists only under the optional feature.

Optional Feature:
- Macro: DISPATCH_REASSIGN_EN.
- Defined:
  - Each slot has an 8-bit age counter, cleared on assignment and incremented each cycle while assigned.
  - At 255 the slot reverts to unassigned and is rescanned with the previous owner's cost forced to 63.
  - If the other car is unavailable, the call stays unassigned until it becomes available.
- Undefined: no counters; assignments persist until served.

Test Plan:
- Reset with rst_n=0 asserted asynchronously mid-S_COST → all outputs 0 immediately, busy=0 after release.
- car0 idle at floor 1, car1 idle at floor 8, pulse hall_up_req[5] → up_lamp[5]=1; car1_up_req[5]=1 within 20 cycles. Then set car1_floor=6, car1_door=1, car1_state=00 → car1_up_req[5]=0 and up_lamp[5]=0 next edge.
- Tie: car0 at floor 3, car1 at floor 5, both idle, pulse hall_down_req[3] → car0_down_req[3]=1, car1 outputs 0.
- Direction penalty: car0 at floor 2 state 01, car1 at floor 7 idle, pulse hall_up_req[0] → costs 17 vs 6 → car1_up_req[0]=1.
- Boundary: pulse hall_down_req[0] and hall_up_req[7] → all lamps and car outputs stay 0 for 50 cycles, busy=0.
- Both car states 11, pulse hall_up_req[2] → up_lamp[2]=1, no carN req. Set car0_state=00 at floor 1 → car0_up_req[2]=1 within 20 cycles.
